tetris_input_ctrl: RTL and testbench

Conditions the four raw Basys3 push-buttons into clean, single-cycle move commands (down, left, right, rott) for the game-logic FSM, all on gm_clk.
- Each button passes through a 2-FF synchroniser and a debouncer.
- left, right and (optionally) down get auto-repeat: an initial pulse, then DAS delay, then ARR-rate pulses.
- rott produces exactly one pulse per press.
- Sits directly upstream of the game-logic block; its outputs drive that block's down/left/right/rott inputs.

---
 rtl/tetris_pkg.sv | 35 +++
 rtl/tetris_btn_debounce.sv | 55 +++++
 rtl/tetris_input_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
// Shared types and defaults for the Tetris input conditioning block.
//   btn_idx_e   : bit position of each button in the 4-bit button vectors
//                 ({rot,right,left,down}).
//   rep_state_e : states of the per-button command FSMs.
//   DEF_*       : default timing parameters, in gm_clk cycles.
//   max_int     : helper used to size the shared repeat counter.
// ---------------------------------------------------------------------------
package tetris_pkg;

   typedef enum logic [1:0] {
      BTN_DOWN  = 2'd0,
      BTN_LEFT  = 2'd1,
      BTN_RIGHT = 2'd2,
      BTN_ROT   = 2'd3
   } btn_idx_e;

   typedef enum logic [1:0] {
      REP_IDLE     = 2'd0,
      REP_DAS      = 2'd1,
      REP_REPEAT   = 2'd2,
      REP_WAIT_REL = 2'd3
   } rep_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_DAS_DELAY       = 10;
   localparam int DEF_ARR_PERIOD      = 3;

   // Larger of two integers, usable in constant expressions.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tetris_btn_debounce.sv
// ---------------------------------------------------------------------------
// tetris_btn_debounce
// Brings one raw, asynchronous push-button into the clock domain through a
// two-flop synchroniser, then only lets the debounced level follow the
// synchronised input once it has disagreed for DEBOUNCE_CYCLES consecutive
// cycles. Shorter glitches never reach the level output.
// Ports:
//   clk   : input  1  sampling clock
//   rst   : input  1  asynchronous active-high reset
//   raw   : input  1  raw button, asynchronous to clk
//   level : output 1  debounced, synchronous button level
// ---------------------------------------------------------------------------
module tetris_btn_debounce
   import tetris_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // The first two flops only resolve metastability. The counter measures
   // how long s2 has disagreed with the current level; any agreement
   // restarts the measurement, so only a steady change flips the level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/tetris_input_ctrl.sv
// ---------------------------------------------------------------------------
// tetris_input_ctrl
// Turns the four Basys3 push-buttons into clean single-cycle move commands
// for the game-logic FSM. Each button is synchronised and debounced; left
// and right auto-repeat (initial pulse, DAS delay, then ARR-rate pulses),
// rott fires once per press. Holding left and right together cancels both.
// Build option:
//   TETRIS_INPUT_DOWN_REPEAT_EN defined   -> down auto-repeats like left/right
//   TETRIS_INPUT_DOWN_REPEAT_EN undefined -> down fires once per press
// Ports:
//   gm_clk        : input  1  game clock
//   gm_rst        : input  1  asynchronous active-high reset
//   en            : input  1  high while the game accepts moves
//   btn_down_raw  : input  1  raw soft-drop button
//   btn_left_raw  : input  1  raw move-left button
//   btn_right_raw : input  1  raw move-right button
//   btn_rot_raw   : input  1  raw rotate button
//   down          : output 1  soft-drop command pulse
//   left          : output 1  move-left command pulse
//   right         : output 1  move-right command pulse
//   rott          : output 1  rotate command pulse
//   held          : output 4  debounced levels {rot,right,left,down}
// ---------------------------------------------------------------------------
module tetris_input_ctrl
   import tetris_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DAS_DELAY       = DEF_DAS_DELAY,
   parameter int ARR_PERIOD      = DEF_ARR_PERIOD
) (
   input  logic       gm_clk,
   input  logic       gm_rst,
   input  logic       en,
   input  logic       btn_down_raw,
   input  logic       btn_left_raw,
   input  logic       btn_right_raw,
   input  logic       btn_rot_raw,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       rott,
   output logic [3:0] held
);

   localparam int RCW = $clog2(max_int(DAS_DELAY, ARR_PERIOD) + 1);
   localparam logic [RCW-1:0] DAS_LAST = RCW'(DAS_DELAY);
   localparam logic [RCW-1:0] ARR_LAST = RCW'(ARR_PERIOD);
   localparam logic [RCW-1:0] RC_ONE   = RCW'(1);

   localparam logic [3:0] HORIZ_MASK = 4'b0110;
`ifdef TETRIS_INPUT_DOWN_REPEAT_EN
   localparam logic [3:0] REPEAT_MASK = 4'b0111;
`else
   localparam logic [3:0] REPEAT_MASK = 4'b0110;
`endif

   logic [3:0]     raw_vec;
   logic [3:0]     db;
   logic           conflict;
   logic [3:0]     allowed;
   logic [3:0]     pulse;
   logic [3:0]     pulse_nxt;
   rep_state_e     state     [4];
   rep_state_e     state_nxt [4];
   logic [RCW-1:0] rc        [4];
   logic [RCW-1:0] rc_nxt    [4];

   assign raw_vec = {btn_rot_raw, btn_right_raw, btn_left_raw, btn_down_raw};

   // One synchroniser/debouncer per button, indexed by btn_idx_e.
   for (genvar g = 0; g < 4; g++) begin : g_db
      tetris_btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (gm_clk),
         .rst  (gm_rst),
         .raw  (raw_vec[g]),
         .level(db[g])
      );
   end

   // A channel may only run while the game accepts moves; left and right
   // additionally cancel each other while both are held, so neither wins.
   assign conflict = db[BTN_LEFT] & db[BTN_RIGHT];
   assign allowed  = {4{en}} & ~({4{conflict}} & HORIZ_MASK);

   // State register: FSM states, repeat counters and the registered
   // command pulses all live here so every output comes straight off a flop.
   always_ff @(posedge gm_clk or posedge gm_rst) begin
      if (gm_rst) begin
         pulse <= '0;
         for (int i = 0; i < 4; i++) begin
            state[i] <= REP_IDLE;
            rc[i]    <= '0;
         end
      end else begin
         pulse <= pulse_nxt;
         for (int i = 0; i < 4; i++) begin
            state[i] <= state_nxt[i];
            rc[i]    <= rc_nxt[i];
         end
      end
   end

   // Output decode: a channel fires on a fresh press in IDLE, when the DAS
   // delay expires, and at every ARR period once repeating. A released or
   // disallowed channel never fires.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pulse_nxt[i] = 1'b0;
         if (allowed[i] && db[i]) begin
            case (state[i])
               REP_IDLE:   pulse_nxt[i] = 1'b1;
               REP_DAS:    pulse_nxt[i] = (rc[i] == DAS_LAST);
               REP_REPEAT: pulse_nxt[i] = (rc[i] == ARR_LAST);
               default:    pulse_nxt[i] = 1'b0;
            endcase
         end
      end
   end

   // Next-state logic. Every fire restarts the counter at 1 so it counts
   // cycles since the last pulse. Single-shot channels park in WAIT_REL
   // after their pulse until the button is released. Disabling or a
   // left/right conflict drops a channel to IDLE so it re-presses later.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_nxt[i] = state[i];
         rc_nxt[i]    = rc[i];
         if (!allowed[i]) begin
            state_nxt[i] = REP_IDLE;
            rc_nxt[i]    = '0;
         end else begin
            case (state[i])
               REP_IDLE: begin
                  if (pulse_nxt[i]) begin
                     rc_nxt[i]    = RC_ONE;
                     state_nxt[i] = REPEAT_MASK[i] ? REP_DAS : REP_WAIT_REL;
                  end
               end
               REP_DAS: begin
                  if (!db[i]) begin
                     state_nxt[i] = REP_IDLE;
                  end else if (pulse_nxt[i]) begin
                     rc_nxt[i]    = RC_ONE;
                     state_nxt[i] = REP_REPEAT;
                  end else begin
                     rc_nxt[i] = rc[i] + RC_ONE;
                  end
               end
               REP_REPEAT: begin
                  if (!db[i]) begin
                     state_nxt[i] = REP_IDLE;
                  end else if (pulse_nxt[i]) begin
                     rc_nxt[i] = RC_ONE;
                  end else begin
                     rc_nxt[i] = rc[i] + RC_ONE;
                  end
               end
               REP_WAIT_REL: begin
                  if (!db[i]) begin
                     state_nxt[i] = REP_IDLE;
                  end
               end
               default: begin
                  state_nxt[i] = REP_IDLE;
               end
            endcase
         end
      end
   end

   assign down  = pulse[BTN_DOWN];
   assign left  = pulse[BTN_LEFT];
   assign right = pulse[BTN_RIGHT];
   assign rott  = pulse[BTN_ROT];
   assign held  = db;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tetris_input_ctrl
// Drives tetris_input_ctrl with directed button scenarios followed by random
// press patterns. A reference model, expressed as debounce windows over the
// raw sample history and pulse times relative to the start of each press,
// pushes the expected outputs of every cycle into a queue; a separate
// monitor pops and compares on each falling edge. Pulse times seen on the
// outputs are also logged for the scenario-level timing checks.
// Honours TETRIS_INPUT_DOWN_REPEAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_tetris_input_ctrl;

   localparam int DB  = 4;
   localparam int DAS = 6;
   localparam int ARR = 2;
`ifdef TETRIS_INPUT_DOWN_REPEAT_EN
   localparam bit DOWN_REP = 1'b1;
`else
   localparam bit DOWN_REP = 1'b0;
`endif

   logic       gm_clk = 1'b0;
   logic       gm_rst = 1'b1;
   logic       en = 1'b0;
   logic       btn_down_raw = 1'b0;
   logic       btn_left_raw = 1'b0;
   logic       btn_right_raw = 1'b0;
   logic       btn_rot_raw = 1'b0;
   logic       down;
   logic       left;
   logic       right;
   logic       rott;
   logic [3:0] held;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] exp_q [$];
   int t_down  [$];
   int t_left  [$];
   int t_right [$];
   int t_rot   [$];

   logic [15:0] hist [4];
   logic [3:0]  mdb;
   bit          mact [4];
   int          mt0  [4];

   tetris_input_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .DAS_DELAY      (DAS),
      .ARR_PERIOD     (ARR)
   ) dut (
      .gm_clk       (gm_clk),
      .gm_rst       (gm_rst),
      .en           (en),
      .btn_down_raw (btn_down_raw),
      .btn_left_raw (btn_left_raw),
      .btn_right_raw(btn_right_raw),
      .btn_rot_raw  (btn_rot_raw),
      .down         (down),
      .left         (left),
      .right        (right),
      .rott         (rott),
      .held         (held)
   );

   // Free-running game clock.
   initial forever #5 gm_clk = ~gm_clk;

   // Hard time limit so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic int time_at(input int b, input int idx);
      case (b)
         0:       return (idx < t_down.size())  ? t_down[idx]  : -1;
         1:       return (idx < t_left.size())  ? t_left[idx]  : -1;
         2:       return (idx < t_right.size()) ? t_right[idx] : -1;
         default: return (idx < t_rot.size())   ? t_rot[idx]   : -1;
      endcase
   endfunction

   function automatic int left_count_between(input int a, input int b);
      int n = 0;
      foreach (t_left[i]) if (t_left[i] >= a && t_left[i] <= b) n++;
      return n;
   endfunction

   function automatic int left_has(input int t);
      foreach (t_left[i]) if (t_left[i] == t) return 1;
      return 0;
   endfunction

   // Reference model for one rising edge. A button's command stream is a
   // press episode starting when it is debounced high, enabled and not in a
   // left/right conflict; pulses sit at offsets 0, DAS, DAS+k*ARR from the
   // episode start (offset 0 only for single-shot buttons). The debounced
   // level flips when the last DB synchronised samples (raw delayed two
   // edges) all disagree with it.
   task automatic model_edge();
      logic [3:0] raws;
      logic [3:0] dbp;
      logic [3:0] p;
      bit         conflict;
      bit         elig;
      bit         rep;
      bit         flip;
      int         d;
      cyc++;
      if (gm_rst) begin
         for (int b = 0; b < 4; b++) begin
            hist[b] = '0;
            mact[b] = 1'b0;
         end
         mdb = '0;
         exp_q.push_back(8'h00);
         return;
      end
      raws     = {btn_rot_raw, btn_right_raw, btn_left_raw, btn_down_raw};
      dbp      = mdb;
      conflict = dbp[1] && dbp[2];
      p        = '0;
      for (int b = 0; b < 4; b++) begin
         elig = dbp[b] && en && !(conflict && (b == 1 || b == 2));
         rep  = (b == 1) || (b == 2) || (b == 0 && DOWN_REP);
         if (!elig) begin
            mact[b] = 1'b0;
         end else if (!mact[b]) begin
            mact[b] = 1'b1;
            mt0[b]  = cyc;
            p[b]    = 1'b1;
         end else if (rep) begin
            d    = cyc - mt0[b];
            p[b] = (d == DAS) || (d > DAS && ((d - DAS) % ARR) == 0);
         end
      end
      for (int b = 0; b < 4; b++) begin
         hist[b] = {hist[b][14:0], raws[b]};
         flip = 1'b1;
         for (int j = 0; j < DB; j++) begin
            if (hist[b][2 + j] == mdb[b]) flip = 1'b0;
         end
         if (flip) mdb[b] = ~mdb[b];
      end
      exp_q.push_back({p[0], p[1], p[2], p[3], mdb});
   endtask

   // Drive a button pattern and enable level, then run n clock edges with
   // the model stepped on each. Entered and left at rising edge + 2.
   task automatic apply_stimulus(input logic [3:0] raw_v, input logic en_v, input int n);
      {btn_rot_raw, btn_right_raw, btn_left_raw, btn_down_raw} = raw_v;
      en = en_v;
      repeat (n) begin
         @(posedge gm_clk);
         model_edge();
         #2;
      end
   endtask

   // Monitor: compares the DUT against the model once per cycle on the
   // falling edge and logs when each command actually pulsed.
   always @(negedge gm_clk) begin : monitor
      logic [7:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_output($sformatf("outputs@cycle%0d", cyc),
                      int'({down, left, right, rott, held}), int'(e));
         if (down)  t_down.push_back(cyc);
         if (left)  t_left.push_back(cyc);
         if (right) t_right.push_back(cyc);
         if (rott)  t_rot.push_back(cyc);
      end
   end

   initial begin : stimulus
      int s;
      for (int b = 0; b < 4; b++) begin
         hist[b] = '0;
         mact[b] = 1'b0;
         mt0[b]  = 0;
      end
      mdb = '0;

      repeat (3) @(posedge gm_clk);
      #2;
      check_output("reset_outputs", int'({down, left, right, rott, held}), 0);
      gm_rst = 1'b0;

      $display("[TB] glitch shorter than debounce window on left");
      t_left.delete();
      apply_stimulus(4'b0010, 1'b1, 3);
      apply_stimulus(4'b0000, 1'b1, 12);
      check_output("glitch_left_pulses", t_left.size(), 0);

      $display("[TB] right held then released");
      t_right.delete();
      s = cyc;
      apply_stimulus(4'b0100, 1'b1, 18);
      apply_stimulus(4'b0000, 1'b1, 15);
      check_output("right_first_pulse",  time_at(2, 0), s + 7);
      check_output("right_das_pulse",    time_at(2, 1), s + 13);
      check_output("right_arr_pulse",    time_at(2, 2), s + 15);
      check_output("right_pulse_count",  t_right.size(), 7);

      $display("[TB] rotate held, single pulse per press");
      t_rot.delete();
      s = cyc;
      apply_stimulus(4'b1000, 1'b1, 50);
      check_output("rot_single_pulse", t_rot.size(), 1);
      check_output("rot_pulse_time",   time_at(3, 0), s + 7);
      apply_stimulus(4'b0000, 1'b1, 10);
      apply_stimulus(4'b1000, 1'b1, 15);
      apply_stimulus(4'b0000, 1'b1, 10);
      check_output("rot_repress_count", t_rot.size(), 2);

      $display("[TB] left/right conflict");
      t_left.delete();
      t_right.delete();
      s = cyc;
      apply_stimulus(4'b0010, 1'b1, 20);
      apply_stimulus(4'b0110, 1'b1, 20);
      apply_stimulus(4'b0010, 1'b1, 20);
      apply_stimulus(4'b0000, 1'b1, 10);
      check_output("conflict_left_silent",  left_count_between(s + 27, s + 46), 0);
      check_output("conflict_right_silent", t_right.size(), 0);
      check_output("conflict_left_fresh",   left_has(s + 47), 1);
      check_output("conflict_left_das",     left_has(s + 53), 1);

      $display("[TB] down held while disabled");
      t_down.delete();
      s = cyc;
      apply_stimulus(4'b0001, 1'b0, 30);
      check_output("disabled_down_silent", t_down.size(), 0);
      apply_stimulus(4'b0001, 1'b1, 15);
      apply_stimulus(4'b0000, 1'b1, 12);
      check_output("enable_down_first",  time_at(0, 0), s + 31);
      check_output("enable_down_second", time_at(0, 1), DOWN_REP ? s + 37 : -1);

      $display("[TB] reset during right repeat");
      t_right.delete();
      apply_stimulus(4'b0100, 1'b1, 20);
      #5;
      gm_rst = 1'b1;
      #1;
      check_output("reset_drop_outputs", int'({down, left, right, rott, held}), 0);
      @(posedge gm_clk);
      model_edge();
      #2;
      apply_stimulus(4'b0100, 1'b1, 2);
      gm_rst = 1'b0;
      t_right.delete();
      s = cyc;
      apply_stimulus(4'b0100, 1'b1, 12);
      check_output("reset_redebounce_first", time_at(2, 0), s + 7);
      apply_stimulus(4'b0000, 1'b1, 12);

      $display("[TB] random press patterns");
      repeat (60) begin
         apply_stimulus(4'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(1, 20));
      end
      apply_stimulus(4'b0000, 1'b1, 12);

      @(negedge gm_clk);
      #1;
      check_output("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
